// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//
// Purpose:
//   Walks an analog multiplexer through NumSensors inputs, one scan per "go".
//   For every sensor it lets the mux settle for SettleCycles+1 clocks, starts
//   the measure channel, waits for the channel to finish and drop its end flag,
//   presents the result to the CPU and waits for the CPU to acknowledge it.
//   After the last sensor a single-cycle scan_done pulse is produced.
//   A CPU abort returns the sequencer to IDLE from any active state.
//
// Parameters:
//   NumSensors   - sensors per scan, 1..32
//   SettleCycles - extra mux settling clocks before each measurement, 0..255
//
// Ports:
//   op_clock   in   block clock, rising edge
//   reset      in   synchronous active-high reset
//   go         in   start one scan (level, honoured only in IDLE)
//   abort      in   terminate the scan in progress
//   meas_end   in   measure channel end-of-measurement flag
//   ack        in   CPU has read the current sensor result
//   sensor_sel out  [4:0] selected sensor index for the mux
//   sensor_en  out  mux enable while a sensor is being handled
//   meas_start out  start level to the measure channel
//   result_rdy out  a sensor result is waiting for ack
//   scan_done  out  one-cycle pulse when the last sensor is acknowledged
//   busy       out  high whenever the sequencer is not IDLE
//
// Every output is a flop loaded from the next-state decode, so outputs change
// on the same edge the FSM enters the state that sets them and there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module scan_sequencer #(
  parameter int NumSensors   = 8,
  parameter int SettleCycles = 16
) (
  input  logic       op_clock,
  input  logic       reset,
  input  logic       go,
  input  logic       abort,
  input  logic       meas_end,
  input  logic       ack,
  output logic [4:0] sensor_sel,
  output logic       sensor_en,
  output logic       meas_start,
  output logic       result_rdy,
  output logic       scan_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEAS    = 3'd2,
    RELEASE = 3'd3,
    RESULT  = 3'd4,
    NEXT    = 3'd5
  } state_e;

  localparam logic [4:0] LastIdx    = 5'(NumSensors - 1);
  localparam logic [7:0] SettleLoad = 8'(SettleCycles);

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] settle_q, settle_d;

  logic [4:0] sensor_sel_q;
  logic       sensor_en_q;
  logic       meas_start_q;
  logic       result_rdy_q;
  logic       scan_done_q;
  logic       busy_q;

  logic       last_sensor;

  assign last_sensor = (idx_q == LastIdx);

  // ---------------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;

    case (state_q)
      IDLE: begin
        if (go) begin
          idx_d    = 5'd0;
          settle_d = SettleLoad;
          state_d  = SETTLE;
        end
      end

      SETTLE: begin
        // The counter is checked before it is decremented, so SETTLE always
        // lasts SettleCycles+1 clocks (a single clock when SettleCycles=0).
        if (settle_q == 8'd0) begin
          state_d = MEAS;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end

      MEAS: begin
        if (meas_end) begin
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        // meas_start is already low here; hold until the channel drops its
        // end flag so the next start is never seen while it is still in END.
        if (!meas_end) begin
          state_d = RESULT;
        end
      end

      RESULT: begin
        if (ack) begin
          state_d = NEXT;
        end
      end

      NEXT: begin
        if (last_sensor) begin
          idx_d   = 5'd0;
          state_d = IDLE;
        end else begin
          idx_d    = idx_q + 5'd1;
          settle_d = SettleLoad;
          state_d  = SETTLE;
        end
      end

      default: begin
        idx_d   = 5'd0;
        state_d = IDLE;
      end
    endcase

    // Abort overrides every other request taken in the same cycle.
    if (abort && (state_q != IDLE)) begin
      idx_d   = 5'd0;
      state_d = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge op_clock) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 5'd0;
      settle_q     <= 8'd0;
      sensor_sel_q <= 5'd0;
      sensor_en_q  <= 1'b0;
      meas_start_q <= 1'b0;
      result_rdy_q <= 1'b0;
      scan_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      sensor_sel_q <= (state_d == IDLE) ? 5'd0 : idx_d;
      sensor_en_q  <= (state_d == SETTLE) || (state_d == MEAS) ||
                      (state_d == RELEASE) || (state_d == RESULT);
      meas_start_q <= (state_d == MEAS);
      result_rdy_q <= (state_d == RESULT);
      // NEXT is only reachable from RESULT on an un-aborted ack, and NEXT
      // always leaves after one clock, so this is a single-cycle pulse.
      scan_done_q  <= (state_d == NEXT) && (idx_d == LastIdx);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign sensor_sel = sensor_sel_q;
  assign sensor_en  = sensor_en_q;
  assign meas_start = meas_start_q;
  assign result_rdy = result_rdy_q;
  assign scan_done  = scan_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer
//
// Two sequencers: dut0 (3 sensors, SettleCycles=2) and dut1 (1 sensor,
// SettleCycles=0). Stimulus pushes the expected event list into a queue; a
// monitor turns DUT output edges into events and compares them in order.
//   MEAS   : meas_start rises    val=sensor_sel aux=SETTLE length in cycles
//   RESULT : result_rdy rises    val=sensor_sel aux=RELEASE length in cycles
//   DONE   : scan_done rises     val=sensor_sel aux=busy
//   IDLE   : busy falls          val={sel,en,meas_start,result_rdy,scan_done}
// -----------------------------------------------------------------------------
module tb_scan_sequencer;

  localparam int EV_MEAS   = 0;
  localparam int EV_RESULT = 1;
  localparam int EV_DONE   = 2;
  localparam int EV_IDLE   = 3;

  typedef struct {
    int inst;
    int kind;
    int val;
    int aux;
  } ev_t;

  ev_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  logic       clk;
  logic       rst       [2];
  logic       go        [2];
  logic       abort     [2];
  logic       meas_end  [2];
  logic       ack_model [2];
  logic       ack_force [2];
  logic [4:0] sel       [2];
  logic       en        [2];
  logic       ms        [2];
  logic       rr        [2];
  logic       sd        [2];
  logic       bz        [2];

  // Measure-channel / CPU model settings per instance
  int d_cyc   [2];
  int h_cyc   [2];
  int ack_cyc [2];
  bit mon_on = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  scan_sequencer #(.NumSensors(3), .SettleCycles(2)) dut0 (
    .op_clock  (clk),
    .reset     (rst[0]),
    .go        (go[0]),
    .abort     (abort[0]),
    .meas_end  (meas_end[0]),
    .ack       (ack_model[0] | ack_force[0]),
    .sensor_sel(sel[0]),
    .sensor_en (en[0]),
    .meas_start(ms[0]),
    .result_rdy(rr[0]),
    .scan_done (sd[0]),
    .busy      (bz[0])
  );

  scan_sequencer #(.NumSensors(1), .SettleCycles(0)) dut1 (
    .op_clock  (clk),
    .reset     (rst[1]),
    .go        (go[1]),
    .abort     (abort[1]),
    .meas_end  (meas_end[1]),
    .ack       (ack_model[1] | ack_force[1]),
    .sensor_sel(sel[1]),
    .sensor_en (en[1]),
    .meas_start(ms[1]),
    .result_rdy(rr[1]),
    .scan_done (sd[1]),
    .busy      (bz[1])
  );

  function automatic string kname(int k);
    case (k)
      EV_MEAS:   return "MEAS";
      EV_RESULT: return "RESULT";
      EV_DONE:   return "DONE";
      default:   return "IDLE";
    endcase
  endfunction

  function automatic int snap(int i);
    return int'({sel[i], en[i], ms[i], rr[i], sd[i]});
  endfunction

  task automatic check(string name, int got, int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end else begin
      $display("ok   %s value=%0d", name, got);
    end
  endtask

  task automatic observe(int inst, int kind, int val, int aux);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event inst=%0d got %s val=%0d aux=%0d required none",
               inst, kname(kind), val, aux);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != inst || e.kind != kind || e.val != val || e.aux != aux) begin
        failures++;
        $display("FAIL event inst=%0d got %s val=%0d aux=%0d required inst=%0d %s val=%0d aux=%0d",
                 inst, kname(kind), val, aux, e.inst, kname(e.kind), e.val, e.aux);
      end else begin
        $display("ok   event inst=%0d %s val=%0d aux=%0d", inst, kname(kind), val, aux);
      end
    end
  endtask

  task automatic push(int inst, int kind, int val, int aux);
    ev_t e;
    e.inst = inst;
    e.kind = kind;
    e.val  = val;
    e.aux  = aux;
    exp_q.push_back(e);
  endtask

  // Expected events for one uninterrupted scan
  task automatic push_scan(int inst, int n, int settle_len, int rel_len);
    for (int s = 0; s < n; s++) begin
      push(inst, EV_MEAS, s, settle_len);
      push(inst, EV_RESULT, s, rel_len);
    end
    push(inst, EV_DONE, n - 1, 1);
    push(inst, EV_IDLE, 0, 0);
  endtask

  task automatic pulse_go(int i);
    @(negedge clk);
    go[i] = 1'b1;
    @(negedge clk);
    go[i] = 1'b0;
  endtask

  // cond: 0 busy low, 1 result_rdy high, 2 MEAS of sensor 1, 3 RELEASE with meas_end high
  task automatic wait_for(int i, int cond, string name);
    int  t;
    bit  hit;
    t   = 0;
    hit = 1'b0;
    while (!hit && t < 300) begin
      @(negedge clk);
      t++;
      case (cond)
        0:       hit = !bz[i];
        1:       hit = rr[i];
        2:       hit = ms[i] && (sel[i] == 5'd1);
        default: hit = en[i] && !ms[i] && !rr[i] && meas_end[i];
      endcase
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s inst=%0d got=timeout required=condition", name, i);
    end
  endtask

  // Measure channel and CPU acknowledge models
  initial begin
    int mcnt[2];
    int hcnt[2];
    int rcnt[2];
    for (int i = 0; i < 2; i++) begin
      meas_end[i]  = 1'b0;
      ack_model[i] = 1'b0;
      mcnt[i] = 0;
      hcnt[i] = 0;
      rcnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst[i]) begin
          meas_end[i]  = 1'b0;
          ack_model[i] = 1'b0;
          mcnt[i] = 0;
          hcnt[i] = 0;
          rcnt[i] = 0;
        end else begin
          if (ms[i]) begin
            hcnt[i] = 0;
            if (!meas_end[i]) begin
              mcnt[i]++;
              if (mcnt[i] >= d_cyc[i]) meas_end[i] = 1'b1;
            end
          end else begin
            mcnt[i] = 0;
            if (meas_end[i]) begin
              hcnt[i]++;
              if (hcnt[i] >= h_cyc[i]) begin
                meas_end[i] = 1'b0;
                hcnt[i] = 0;
              end
            end
          end
          if (rr[i]) begin
            rcnt[i]++;
            ack_model[i] = (rcnt[i] == ack_cyc[i]);
          end else begin
            rcnt[i] = 0;
            ack_model[i] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: output edges become events checked against the queue
  initial begin
    logic p_en[2], p_ms[2], p_rr[2], p_sd[2], p_bz[2];
    int   settle_cnt[2];
    int   rel_cnt[2];
    bit   in_settle[2];
    bit   in_rel[2];
    for (int i = 0; i < 2; i++) begin
      p_en[i] = 1'b0; p_ms[i] = 1'b0; p_rr[i] = 1'b0; p_sd[i] = 1'b0; p_bz[i] = 1'b0;
      settle_cnt[i] = 0; rel_cnt[i] = 0; in_settle[i] = 1'b0; in_rel[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (mon_on) begin
        for (int i = 0; i < 2; i++) begin
          if (en[i] && !p_en[i]) begin
            settle_cnt[i] = 1;
            in_settle[i]  = 1'b1;
          end else if (in_settle[i] && en[i] && !ms[i]) begin
            settle_cnt[i]++;
          end
          if (ms[i] && !p_ms[i]) begin
            observe(i, EV_MEAS, int'(sel[i]), settle_cnt[i]);
            in_settle[i] = 1'b0;
            in_rel[i]    = 1'b0;
          end
          if (!ms[i] && p_ms[i] && en[i]) begin
            in_rel[i]  = 1'b1;
            rel_cnt[i] = 1;
          end else if (in_rel[i] && en[i] && !rr[i]) begin
            rel_cnt[i]++;
          end
          if (rr[i] && !p_rr[i]) begin
            observe(i, EV_RESULT, int'(sel[i]), rel_cnt[i]);
            in_rel[i] = 1'b0;
          end
          if (sd[i] && !p_sd[i]) observe(i, EV_DONE, int'(sel[i]), int'(bz[i]));
          if (!bz[i] && p_bz[i]) observe(i, EV_IDLE, snap(i), 0);
          p_en[i] = en[i]; p_ms[i] = ms[i]; p_rr[i] = rr[i]; p_sd[i] = sd[i]; p_bz[i] = bz[i];
        end
      end
    end
  end

  // Stimulus
  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; go[i] = 1'b0; abort[i] = 1'b0; ack_force[i] = 1'b0;
      d_cyc[i] = 5; h_cyc[i] = 1; ack_cyc[i] = 1;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    check("reset_outputs_dut0", snap(0) * 2 + int'(bz[0]), 0);
    check("reset_outputs_dut1", snap(1) * 2 + int'(bz[1]), 0);
    mon_on = 1'b1;

    // Full scan, three sensors, settle 3 cycles each
    push_scan(0, 3, 3, 1);
    pulse_go(0);
    wait_for(0, 0, "full_scan");

    // Ignored inputs: ack during SETTLE, go during RESULT
    ack_cyc[0] = 4;
    push_scan(0, 3, 3, 1);
    @(negedge clk);
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    ack_force[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ack_force[0] = 1'b0;
    wait_for(0, 1, "result_for_go");
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    wait_for(0, 0, "ignored_inputs");
    ack_cyc[0] = 1;

    // Abort in MEAS of sensor 1 with ack in the same cycle, then restart
    push(0, EV_MEAS, 0, 3);
    push(0, EV_RESULT, 0, 1);
    push(0, EV_MEAS, 1, 3);
    push(0, EV_IDLE, 0, 0);
    pulse_go(0);
    wait_for(0, 2, "meas_sensor1");
    abort[0] = 1'b1;
    ack_force[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    ack_force[0] = 1'b0;
    push_scan(0, 3, 3, 1);
    pulse_go(0);
    wait_for(0, 0, "restart_after_abort");

    // Abort in RELEASE while meas_end is high, go at once, then a scan whose
    // meas_end lingers 4 cycles after meas_start falls
    h_cyc[0] = 4;
    push(0, EV_MEAS, 0, 3);
    push(0, EV_IDLE, 0, 0);
    push_scan(0, 3, 3, 4);
    pulse_go(0);
    wait_for(0, 3, "release_meas_end");
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    wait_for(0, 0, "handshake_scan");
    h_cyc[0] = 1;

    // Reset while in RESULT, then a normal scan
    ack_cyc[0] = 4;
    push(0, EV_MEAS, 0, 3);
    push(0, EV_RESULT, 0, 1);
    push(0, EV_IDLE, 0, 0);
    pulse_go(0);
    wait_for(0, 1, "result_for_reset");
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    ack_cyc[0] = 1;
    push_scan(0, 3, 3, 1);
    pulse_go(0);
    wait_for(0, 0, "scan_after_reset");

    // Single sensor, zero settle
    push_scan(1, 1, 1, 1);
    pulse_go(1);
    wait_for(1, 0, "single_sensor");

    repeat (4) @(negedge clk);
    check("expected_events_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
